// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// State encodings, default timing constants and counter sizing.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    S_RESET_PLL = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_e;

  localparam int unsigned DEF_RST_CYCLES    = 27;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 27000;
  localparam int unsigned DEF_STABLE_CYCLES = 2700;
  localparam int unsigned DEF_MAX_RETRIES   = 4;

  function automatic int unsigned cnt_width(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous single-bit status inputs.
// Ports: clkin/reset (async, active-high), d async in, q synced out.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clkin,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences the pixel-clock rPLL: reset pulse, lock wait/retry,
// lock-stable qualification and downstream reset release.
// Ports: clkin, reset (async high), pll_lock (async), relock_req;
// outputs pll_reset, sys_reset, locked, fail, relock_count, state.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       locked,
  output logic       fail,
  output logic [7:0] relock_count,
  output logic [1:0] state
);

  localparam int unsigned CW =
    cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that first sees lock counts as stable
  // cycle one, so STABLE itself needs STABLE_CYCLES-1 cycles.
  localparam logic [CW-1:0] STB_LAST =
    CW'((STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0);
  localparam logic      DIRECT_RUN = (STABLE_CYCLES == 1);
  localparam logic [7:0] MAX_RET   = 8'(MAX_RETRIES);

  logic lock_s;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]  retry_q, retry_d;
  logic [7:0]  rc_q, rc_d;
  logic        fail_q, fail_d;
  logic        pll_reset_q, pll_reset_d;
  logic        sys_reset_q, sys_reset_d;
  logic        locked_q, locked_d;
  logic [7:0]  retry_inc;
  logic        run_exit;

  sync_2ff #(
    .RST_VAL (1'b0)
  ) u_lock_sync (
    .clkin (clkin),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign retry_inc = retry_q + {7'd0, retry_q != 8'hFF};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    fail_d   = fail_q;
    rc_d     = rc_q;
    run_exit = 1'b0;

    if (relock_req) begin
      state_d  = S_RESET_PLL;
      run_exit = (state_q == S_RUN);
    end else begin
      case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = DIRECT_RUN ? S_RUN : S_STABLE;
          end else if (cnt_q == TO_LAST) begin
            state_d = S_RESET_PLL;
            retry_d = retry_inc;
            if (retry_inc == MAX_RET) fail_d = 1'b1;
          end
        end
        S_STABLE: begin
          if (!lock_s) state_d = S_WAIT_LOCK;
          else if (cnt_q == STB_LAST) state_d = S_RUN;
        end
        S_RUN: begin
          if (!lock_s) begin
            state_d  = S_RESET_PLL;
            run_exit = 1'b1;
          end
        end
        default: state_d = S_RESET_PLL;
      endcase
    end

    if (run_exit && rc_q != 8'hFF) rc_d = rc_q + 8'd1;

    if (state_d == S_RUN && state_q != S_RUN) retry_d = 8'd0;

    // Counter restarts on every entry; it idles in RUN.
    if (state_d != state_q || relock_req) cnt_d = '0;
    else if (state_q != S_RUN) cnt_d = cnt_q + CW'(1);

    pll_reset_d = (state_d == S_RESET_PLL);
    sys_reset_d = (state_d != S_RUN);
    locked_d    = (state_d == S_RUN);
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= 8'd0;
      rc_q        <= 8'd0;
      fail_q      <= 1'b0;
      pll_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      rc_q        <= rc_d;
      fail_q      <= fail_d;
      pll_reset_q <= pll_reset_d;
      sys_reset_q <= sys_reset_d;
      locked_q    <= locked_d;
    end
  end

  assign pll_reset    = pll_reset_q;
  assign sys_reset    = sys_reset_q;
  assign locked       = locked_q;
  assign fail         = fail_q;
  assign relock_count = rc_q;
  assign state        = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer: directed scenarios plus random
// lock/relock traffic, checked every cycle against a reference model.
module tb_pll_reset_sequencer;

  localparam int RST  = 4;
  localparam int TMO  = 20;
  localparam int STB  = 8;
  localparam int MAXR = 2;

  localparam int PH_RST  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_STB  = 2;
  localparam int PH_RUN  = 3;

  logic       clkin;
  logic       reset;
  logic       pll_lock;
  logic       relock_req;
  logic       pll_reset;
  logic       sys_reset;
  logic       locked;
  logic       fail;
  logic [7:0] relock_count;
  logic [1:0] state;

  int vectors;
  int miscompares;

  int m_ph;
  int m_el;
  int m_streak;
  int m_retry;
  int m_rc;
  bit m_fail;
  bit hist[$];

  pll_reset_sequencer #(
    .RST_CYCLES    (RST),
    .LOCK_TIMEOUT  (TMO),
    .STABLE_CYCLES (STB),
    .MAX_RETRIES   (MAXR)
  ) dut (
    .clkin        (clkin),
    .reset        (reset),
    .pll_lock     (pll_lock),
    .relock_req   (relock_req),
    .pll_reset    (pll_reset),
    .sys_reset    (sys_reset),
    .locked       (locked),
    .fail         (fail),
    .relock_count (relock_count),
    .state        (state)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    m_ph     = PH_RST;
    m_el     = 0;
    m_streak = 0;
    m_retry  = 0;
    m_rc     = 0;
    m_fail   = 1'b0;
    hist     = '{1'b0, 1'b0};
  endtask

  // Lock seen by the sequencer is pll_lock from two edges earlier.
  task automatic model_step();
    bit ls;
    int nph;
    if (reset) begin
      model_init();
      return;
    end
    ls = hist.pop_front();
    hist.push_back(pll_lock);
    nph = m_ph;
    if (relock_req) nph = PH_RST;
    else if (m_ph == PH_RST) begin
      if (m_el + 1 >= RST) nph = PH_WAIT;
    end else if (m_ph == PH_WAIT) begin
      if (ls) begin
        m_streak = 1;
        nph = (m_streak >= STB) ? PH_RUN : PH_STB;
      end else if (m_el + 1 >= TMO) begin
        nph = PH_RST;
        if (m_retry < 255) m_retry++;
        if (m_retry == MAXR) m_fail = 1'b1;
      end
    end else if (m_ph == PH_STB) begin
      if (!ls) nph = PH_WAIT;
      else begin
        m_streak++;
        if (m_streak >= STB) nph = PH_RUN;
      end
    end else begin
      if (!ls) nph = PH_RST;
    end
    if (m_ph == PH_RUN && nph != PH_RUN && m_rc < 255) m_rc++;
    if (nph == PH_RUN && m_ph != PH_RUN) m_retry = 0;
    m_el = (nph != m_ph || relock_req) ? 0 : m_el + 1;
    m_ph = nph;
  endtask

  task automatic cyc();
    logic [13:0] e;
    logic [13:0] o;
    @(posedge clkin);
    model_step();
    #1;
    e = {2'(m_ph), m_ph == PH_RST, m_ph != PH_RUN,
         m_ph == PH_RUN, m_fail, 8'(m_rc)};
    o = {state, pll_reset, sys_reset, locked, fail, relock_count};
    chk("cycle", 32'(o), 32'(e));
  endtask

  task automatic wait_state(input int tgt, input int budget,
                            input string tag);
    int n;
    n = 0;
    while (int'(state) != tgt && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, 32'(state), 32'(tgt));
  endtask

  task automatic pulse_relock();
    relock_req = 1'b1;
    cyc();
    relock_req = 1'b0;
  endtask

  initial begin
    int n;
    int rc0;
    int hold;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    pll_lock    = 1'b0;
    relock_req  = 1'b0;
    model_init();
    cyc();
    cyc();
    chk("reset_vals",
        32'({state, pll_reset, sys_reset, locked, fail, relock_count}),
        32'(14'b00_1_1_0_0_00000000));

    // Bring-up: pll_reset hold, then lock-to-release latency.
    reset = 1'b0;
    n = 0;
    do begin cyc(); n++; end while (pll_reset && n < 50);
    chk("pll_reset_len", 32'(n), 32'(RST));
    repeat (6) cyc();
    pll_lock = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (sys_reset && n < 100);
    chk("lock_to_release", 32'(n), 32'(2 + STB));
    chk("locked_run", 32'(locked), 32'd1);
    chk("rc_zero", 32'(relock_count), 32'd0);

    // One-cycle lock drop in RUN.
    pll_lock = 1'b0;
    cyc();
    pll_lock = 1'b1;
    cyc();
    cyc();
    chk("drop_state", 32'(state), 32'(PH_RST));
    chk("drop_resets", 32'({sys_reset, pll_reset}), 32'd3);
    chk("drop_rc", 32'(relock_count), 32'd1);
    wait_state(PH_RUN, 100, "reseq_run");

    // Persistent lock loss: timeouts and sticky fail.
    pll_lock = 1'b0;
    wait_state(PH_RST, 10, "loss_rst");
    repeat (RST + TMO) cyc();
    chk("to1_state", 32'(state), 32'(PH_RST));
    chk("to1_fail", 32'(fail), 32'd0);
    repeat (RST + TMO) cyc();
    chk("to2_fail", 32'(fail), 32'd1);
    repeat (RST + TMO) cyc();
    chk("to3_fail", 32'(fail), 32'd1);
    pll_lock = 1'b1;
    wait_state(PH_RUN, 100, "fail_run");
    chk("fail_in_run", 32'({fail, locked}), 32'd3);

    // Lock glitch inside STABLE.
    pulse_relock();
    wait_state(PH_STB, 100, "to_stable");
    repeat (2) cyc();
    pll_lock = 1'b0;
    cyc();
    pll_lock = 1'b1;
    cyc();
    cyc();
    chk("glitch_wait", 32'(state), 32'(PH_WAIT));
    chk("glitch_sysrst", 32'(sys_reset), 32'd1);
    n = 2;
    while (!locked && n < 100) begin cyc(); n++; end
    chk("glitch_release", 32'(n), 32'(2 + STB));

    // relock_req coinciding with lock_s drop in RUN.
    rc0 = int'(relock_count);
    pll_lock = 1'b0;
    cyc();
    cyc();
    pulse_relock();
    chk("coinc_state", 32'(state), 32'(PH_RST));
    chk("coinc_rc", 32'(relock_count), 32'(rc0 + 1));
    repeat (3) cyc();
    chk("coinc_rc2", 32'(relock_count), 32'(rc0 + 1));

    // relock_req in WAIT_LOCK.
    wait_state(PH_WAIT, 20, "to_wait");
    repeat (3) cyc();
    pulse_relock();
    chk("wait_relock", 32'(state), 32'(PH_RST));
    chk("wait_rc", 32'(relock_count), 32'(rc0 + 1));
    pll_lock = 1'b1;

    // Saturation of relock_count.
    for (int i = 0; i < 300; i++) begin
      wait_state(PH_RUN, 100, "sat_run");
      pulse_relock();
    end
    chk("rc_sat", 32'(relock_count), 32'd255);

    // Asynchronous reset mid-STABLE.
    wait_state(PH_STB, 100, "pre_areset");
    cyc();
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset",
        32'({state, pll_reset, sys_reset, locked, fail, relock_count}),
        32'(14'b00_1_1_0_0_00000000));
    model_init();
    cyc();
    reset = 1'b0;
    n = 0;
    do begin cyc(); n++; end while (pll_reset && n < 50);
    chk("rst_hold_again", 32'(n), 32'(RST));

    // Random lock traffic with occasional relock requests.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        pll_lock = 1'($urandom_range(0, 1));
        hold = int'($urandom_range(1, 40));
      end
      hold--;
      relock_req = ($urandom_range(0, 63) == 0);
      cyc();
    end
    relock_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
